// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-leg complementary PWM bridge:
// default widths, minimum carrier half-period and the carrier direction.
package pwm_pkg;

  localparam int unsigned CW_DEF  = 16;  // carrier / duty width
  localparam int unsigned DTW_DEF = 8;   // dead-time width
  localparam int unsigned HP_MIN  = 2;   // smallest half-period the carrier accepts

  // Carrier direction; UP is the reset / disabled direction.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_bridge_nleg_if.sv
// Control-side bus of the PWM bridge: configuration and fault handshake in,
// gate drives and carrier status out. Clock and reset stay plain ports.
interface pwm_bridge_nleg_if
  import pwm_pkg::*;
#(
  parameter int unsigned LEGS = 3,
  parameter int unsigned CW   = CW_DEF,
  parameter int unsigned DTW  = DTW_DEF
);

  logic                 en;           // run enable
  logic [LEGS*CW-1:0]   duty;         // leg i at [i*CW +: CW]
  logic [CW-1:0]        half_period;  // carrier peak
  logic [DTW-1:0]       deadtime;     // dead time in clk cycles
  logic                 cfg_valid;    // capture strobe into pending regs
  logic                 fault;        // protection request, level
  logic                 fault_clr;    // clear request for the latched fault
  logic [LEGS-1:0]      pwm_hi;       // high-side gates
  logic [LEGS-1:0]      pwm_lo;       // low-side gates
  logic                 fault_lat;    // latched fault status
  logic                 valley;       // shadow-load pulse
  logic [CW-1:0]        cnt;          // carrier value

  // Control loop / protection side.
  modport master (
    output en, duty, half_period, deadtime, cfg_valid, fault, fault_clr,
    input  pwm_hi, pwm_lo, fault_lat, valley, cnt
  );

  // PWM generator side.
  modport slave (
    input  en, duty, half_period, deadtime, cfg_valid, fault, fault_clr,
    output pwm_hi, pwm_lo, fault_lat, valley, cnt
  );

endinterface

// File: rtl/pwm_leg_cmp.sv
// One half-bridge leg: compares the carrier against duty and dead time and
// registers the complementary gate pair. Comparisons are done one bit wider
// than the carrier so cnt + T and D + T can never wrap.
module pwm_leg_cmp
  import pwm_pkg::*;
#(
  parameter int unsigned CW  = CW_DEF,
  parameter int unsigned DTW = DTW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CW-1:0]  cnt,
  input  logic [CW-1:0]  d,
  input  logic [DTW-1:0] t,
  input  logic           gate_en,
  output logic           hi,
  output logic           lo
);

  localparam int unsigned WW = CW + 1;

  logic [WW-1:0] cnt_w;
  logic [WW-1:0] d_w;
  logic [WW-1:0] t_w;
  logic          hi_on;
  logic          lo_on;

  assign cnt_w = WW'(cnt);
  assign d_w   = WW'(d);
  assign t_w   = WW'(t);

  // High side conducts below D - T, low side from D + T up; the band in
  // between is the dead time where both are off. The two ranges cannot overlap.
  assign hi_on = (cnt_w + t_w) < d_w;
  assign lo_on = cnt_w >= (d_w + t_w);

  // Registered gate outputs, forced off whenever the gates are not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 1'b0;
      lo <= 1'b0;
    end else begin
      hi <= gate_en & hi_on;
      lo <= gate_en & lo_on;
    end
  end

endmodule

// File: rtl/pwm_bridge_nleg.sv
// Multi-leg complementary PWM generator. A centre-aligned up/down carrier is
// shared by all legs; duty, half-period and dead time are double-buffered and
// only move from pending to active at the carrier valley. A latched fault
// blanks every gate until it is cleared and the next valley is reached.
module pwm_bridge_nleg
  import pwm_pkg::*;
#(
  parameter int unsigned LEGS   = 3,
  parameter int unsigned CW     = CW_DEF,
  parameter int unsigned DTW    = DTW_DEF,
  parameter int unsigned HP_RST = 200,
  parameter int unsigned DT_RST = 10
) (
  input logic              clk,
  input logic              rst,
  pwm_bridge_nleg_if.slave bus
);

  // Carrier state
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  dir_e           dir_q;
  dir_e           dir_d;

  // Pending (written by cfg_valid) and active (used by the comparators) sets
  logic [CW-1:0]  pend_duty [LEGS];
  logic [CW-1:0]  pend_hp;
  logic [DTW-1:0] pend_dt;
  logic [CW-1:0]  act_duty  [LEGS];
  logic [CW-1:0]  act_hp;
  logic [DTW-1:0] act_dt;

  // Values the active set takes at the next valley
  logic [CW-1:0]  hp_clamped;
  logic [CW-1:0]  duty_clamped [LEGS];

  logic           load;
  logic           gate_en;
  logic           fault_lat_q;
  logic           gate_block_q;
  logic           valley_q;
  logic [LEGS-1:0] hi_w;
  logic [LEGS-1:0] lo_w;

  // The valley: bottom of the carrier heading up while running. Because a
  // disabled carrier parks at 0/UP, the first enabled cycle is also a valley.
  assign load = bus.en && (cnt_q == '0) && (dir_q == DIR_UP);

  // Fault input blanks the gates directly (one registered stage to the pins);
  // the block flag holds them off from latch until the first valley after clear.
  assign gate_en = bus.en && !bus.fault && !gate_block_q;

  // Carrier next state: count toward the turning point, flip on arrival.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!bus.en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d >= act_hp) dir_d = DIR_DOWN;
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_d == '0) dir_d = DIR_UP;
    end
  end

  // Carrier state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Clamp the pending set as it would be loaded: HP floor, duty ceiling at HP.
  always_comb begin
    hp_clamped = (pend_hp < CW'(HP_MIN)) ? CW'(HP_MIN) : pend_hp;
    for (int i = 0; i < LEGS; i++) begin
      duty_clamped[i] = (pend_duty[i] > hp_clamped) ? hp_clamped : pend_duty[i];
    end
  end

  // Shadow registers: capture on cfg_valid, transfer at the valley. A capture in
  // the valley cycle lands in pending only, since load reads pre-edge pending.
  always_ff @(posedge clk) begin
    // NOTE: these arrays are a few flops per leg, not a RAM, so they are reset;
    // the first valley must load defined values.
    if (rst) begin
      pend_hp  <= CW'(HP_RST);
      pend_dt  <= DTW'(DT_RST);
      act_hp   <= CW'(HP_RST);
      act_dt   <= DTW'(DT_RST);
      valley_q <= 1'b0;
      for (int i = 0; i < LEGS; i++) begin
        pend_duty[i] <= '0;
        act_duty[i]  <= '0;
      end
    end else begin
      valley_q <= load;
      if (load) begin
        act_hp <= hp_clamped;
        act_dt <= pend_dt;
        for (int i = 0; i < LEGS; i++) begin
          act_duty[i] <= duty_clamped[i];
        end
      end
      if (bus.cfg_valid) begin
        pend_hp <= bus.half_period;
        pend_dt <= bus.deadtime;
        for (int i = 0; i < LEGS; i++) begin
          pend_duty[i] <= bus.duty[i*CW +: CW];
        end
      end
    end
  end

  // Fault latch and gate block. A clear only wins while fault is low; the block
  // releases at a valley seen with the latch already clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_lat_q  <= 1'b0;
      gate_block_q <= 1'b0;
    end else begin
      if (bus.fault) begin
        fault_lat_q <= 1'b1;
      end else if (bus.fault_clr) begin
        fault_lat_q <= 1'b0;
      end
      if (bus.fault) begin
        gate_block_q <= 1'b1;
      end else if (load && !fault_lat_q) begin
        gate_block_q <= 1'b0;
      end
    end
  end

  // One comparator / output register per leg.
  for (genvar i = 0; i < LEGS; i++) begin : g_leg
    pwm_leg_cmp #(
      .CW  (CW),
      .DTW (DTW)
    ) u_leg (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt_q),
      .d       (act_duty[i]),
      .t       (act_dt),
      .gate_en (gate_en),
      .hi      (hi_w[i]),
      .lo      (lo_w[i])
    );
  end

  assign bus.pwm_hi    = hi_w;
  assign bus.pwm_lo    = lo_w;
  assign bus.fault_lat = fault_lat_q;
  assign bus.valley    = valley_q;
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_pwm_bridge_nleg.sv
// Bench for pwm_bridge_nleg: a cycle model predicts every output word, which
// is queued when stimulus is driven and compared one clock later. A table of
// configurations checks per-period on-time counts; hand sequences cover duty
// update at the valley, fault latch/clear and mid-period reset.
module tb_pwm_bridge_nleg;

  localparam int LEGS = 3;
  localparam int CW   = 16;
  localparam int DTW  = 8;

  logic clk = 1'b0;
  logic rst;

  pwm_bridge_nleg_if #(.LEGS(LEGS), .CW(CW), .DTW(DTW)) bus ();

  pwm_bridge_nleg #(
    .LEGS(LEGS), .CW(CW), .DTW(DTW), .HP_RST(200), .DT_RST(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0]   cnt;
    logic [LEGS-1:0] hi;
    logic [LEGS-1:0] lo;
    logic            flat;
    logic            valley;
  } obs_t;

  typedef struct {
    int hp;
    int dt;
    int d;
    int n_hi;
    int n_lo;
    int per;
  } vec_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int              m_cnt, m_hp, m_dt, p_hp, p_dt;
  int              m_d [LEGS];
  int              p_d [LEGS];
  bit              m_up, m_flat, m_block, m_valley;
  bit [LEGS-1:0]   m_hi, m_lo;

  // Valley period tracking
  int cyc = 0;
  int v_last = 0;
  int v_hp = 0;
  bit v_ok = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_up = 1'b1; m_hp = 200; m_dt = 10; p_hp = 200; p_dt = 10;
    for (int i = 0; i < LEGS; i++) begin
      m_d[i] = 0;
      p_d[i] = 0;
    end
    m_flat = 1'b0; m_block = 1'b0; m_valley = 1'b0; m_hi = '0; m_lo = '0;
  endtask

  // Predict the outputs visible after the coming clock edge.
  task automatic model_cycle();
    bit   ld, ge;
    obs_t e;
    if (rst) begin
      model_reset();
    end else begin
      ld = bus.en && (m_cnt == 0) && m_up;
      ge = bus.en && !bus.fault && !m_block;
      for (int i = 0; i < LEGS; i++) begin
        m_hi[i] = ge && (m_cnt + m_dt < m_d[i]);
        m_lo[i] = ge && (m_cnt >= m_d[i] + m_dt);
      end
      if (bus.fault) m_block = 1'b1;
      else if (ld && !m_flat) m_block = 1'b0;
      if (bus.fault) m_flat = 1'b1;
      else if (bus.fault_clr) m_flat = 1'b0;
      if (!bus.en) begin
        m_cnt = 0; m_up = 1'b1;
      end else if (m_up) begin
        m_cnt++;
        if (m_cnt >= m_hp) m_up = 1'b0;
      end else begin
        m_cnt--;
        if (m_cnt == 0) m_up = 1'b1;
      end
      if (ld) begin
        m_hp = (p_hp < 2) ? 2 : p_hp;
        m_dt = p_dt;
        for (int i = 0; i < LEGS; i++) m_d[i] = (p_d[i] > m_hp) ? m_hp : p_d[i];
      end
      if (bus.cfg_valid) begin
        p_hp = int'(bus.half_period);
        p_dt = int'(bus.deadtime);
        for (int i = 0; i < LEGS; i++) p_d[i] = int'(bus.duty[i*CW +: CW]);
      end
      m_valley = ld;
    end
    e = {CW'(m_cnt), m_hi, m_lo, m_flat, m_valley};
    exp_q.push_back(e);
  endtask

  // One clock: predict, clock, then compare on the falling edge.
  task automatic step();
    obs_t e, a;
    model_cycle();
    if (!bus.en || rst) v_ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = exp_q.pop_front();
    a = {bus.cnt, bus.pwm_hi, bus.pwm_lo, bus.fault_lat, bus.valley};
    check("scoreboard", a, e);
    check("hi_lo_overlap", bus.pwm_hi & bus.pwm_lo, '0);
    if (bus.valley) begin
      if (v_ok) check("valley_period", cyc - v_last, 2 * v_hp);
      v_last = cyc;
      v_hp   = m_hp;
      v_ok   = 1'b1;
    end
  endtask

  task automatic cfg(input int d0, input int d1, input int d2, input int hp, input int dt);
    bus.duty        = {CW'(d2), CW'(d1), CW'(d0)};
    bus.half_period = CW'(hp);
    bus.deadtime    = DTW'(dt);
    bus.cfg_valid   = 1'b1;
    step();
    bus.cfg_valid   = 1'b0;
  endtask

  // Step at least once, until a valley pulse or the budget runs out.
  task automatic wait_valley(input int budget, input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.valley && n < budget);
    check(name, bus.valley, 1);
  endtask

  vec_t tbl [9];

  initial begin
    int n, n2;
    int nh [LEGS];
    int nl [LEGS];

    tbl[0] = '{hp: 10, dt: 2, d: 5,  n_hi: 5,  n_lo: 7,  per: 20};
    tbl[1] = '{hp: 10, dt: 2, d: 1,  n_hi: 0,  n_lo: 15, per: 20};
    tbl[2] = '{hp: 10, dt: 2, d: 15, n_hi: 15, n_lo: 0,  per: 20};
    tbl[3] = '{hp: 10, dt: 0, d: 5,  n_hi: 9,  n_lo: 11, per: 20};
    tbl[4] = '{hp: 1,  dt: 0, d: 1,  n_hi: 1,  n_lo: 3,  per: 4};
    tbl[5] = '{hp: 10, dt: 2, d: 0,  n_hi: 0,  n_lo: 17, per: 20};
    tbl[6] = '{hp: 10, dt: 5, d: 5,  n_hi: 0,  n_lo: 1,  per: 20};
    tbl[7] = '{hp: 20, dt: 3, d: 9,  n_hi: 11, n_lo: 17, per: 40};
    tbl[8] = '{hp: 0,  dt: 1, d: 3,  n_hi: 1,  n_lo: 0,  per: 4};

    rst = 1'b1;
    bus.en = 1'b0; bus.duty = '0; bus.half_period = '0; bus.deadtime = '0;
    bus.cfg_valid = 1'b0; bus.fault = 1'b0; bus.fault_clr = 1'b0;
    model_reset();
    step();
    step();
    check("reset_cnt", bus.cnt, 0);
    check("reset_hi", bus.pwm_hi, 0);
    check("reset_lo", bus.pwm_lo, 0);
    check("reset_fault_lat", bus.fault_lat, 0);
    check("reset_valley", bus.valley, 0);

    rst = 1'b0;
    bus.en = 1'b1;

    // Table: per-period on-time of each gate, plus period length.
    for (int v = 0; v < 9; v++) begin
      cfg(tbl[v].d, tbl[v].d, tbl[v].d, tbl[v].hp, tbl[v].dt);
      wait_valley(450, "tbl_load_valley", n);
      for (int i = 0; i < LEGS; i++) begin
        nh[i] = 0;
        nl[i] = 0;
      end
      n = 0;
      do begin
        step();
        n++;
        for (int i = 0; i < LEGS; i++) begin
          nh[i] += int'(bus.pwm_hi[i]);
          nl[i] += int'(bus.pwm_lo[i]);
        end
      end while (!bus.valley && n < 100);
      check($sformatf("tbl%0d_period", v), n, tbl[v].per);
      for (int i = 0; i < LEGS; i++) begin
        check($sformatf("tbl%0d_leg%0d_hi_cycles", v, i), nh[i], tbl[v].n_hi);
        check($sformatf("tbl%0d_leg%0d_lo_cycles", v, i), nl[i], tbl[v].n_lo);
      end
    end

    // Duty change mid-period is held until the valley.
    cfg(5, 5, 5, 10, 2);
    wait_valley(30, "dup_valley_a", n);
    wait_valley(30, "dup_valley_b", n);
    cfg(8, 5, 5, 10, 2);
    for (int k = 0; k < 3; k++) step();
    check("dup_cnt_before", bus.cnt, 5);
    check("dup_hi0_old_duty", bus.pwm_hi[0], 0);
    wait_valley(30, "dup_valley_c", n);
    for (int k = 0; k < 3; k++) step();
    check("dup_cnt_after", bus.cnt, 4);
    check("dup_hi0_new_duty", bus.pwm_hi[0], 1);
    check("dup_hi1_unchanged", bus.pwm_hi[1], 0);

    // Fault latch, blocked clear, clear, resume at the valley.
    cfg(5, 5, 5, 10, 2);
    wait_valley(30, "flt_valley_a", n);
    wait_valley(30, "flt_valley_b", n);
    for (int k = 0; k < 3; k++) step();
    check("flt_cnt_at_fault", bus.cnt, 4);
    bus.fault = 1'b1;
    step();
    bus.fault = 1'b0;
    check("flt_hi_off", bus.pwm_hi, 0);
    check("flt_lo_off", bus.pwm_lo, 0);
    check("flt_latched", bus.fault_lat, 1);
    bus.fault = 1'b1;
    bus.fault_clr = 1'b1;
    step();
    bus.fault = 1'b0;
    bus.fault_clr = 1'b0;
    check("flt_clr_while_fault", bus.fault_lat, 1);
    step();
    step();
    check("flt_still_latched", bus.fault_lat, 1);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    check("flt_cleared", bus.fault_lat, 0);
    n = 0;
    do begin
      step();
      n++;
      check("flt_blank_until_valley", {bus.pwm_hi, bus.pwm_lo}, 0);
    end while (!bus.valley && n < 30);
    check("flt_resume_valley", bus.valley, 1);
    step();
    check("flt_resume_hi", bus.pwm_hi, 3'b111);

    // Mid-period reset restores defaults (HP 200, DT 10, duty 0).
    cfg(5, 5, 5, 30, 2);
    wait_valley(30, "rst_valley_a", n);
    bus.fault = 1'b1;
    step();
    bus.fault = 1'b0;
    for (int k = 0; k < 6; k++) step();
    rst = 1'b1;
    step();
    check("mrst_cnt", bus.cnt, 0);
    check("mrst_hi", bus.pwm_hi, 0);
    check("mrst_lo", bus.pwm_lo, 0);
    check("mrst_fault_lat", bus.fault_lat, 0);
    check("mrst_valley", bus.valley, 0);
    rst = 1'b0;
    step();
    check("mrst_first_valley", bus.valley, 1);
    for (int k = 0; k < 9; k++) step();
    check("mrst_cnt10", bus.cnt, 10);
    check("mrst_lo_before_dt", bus.pwm_lo, 0);
    step();
    check("mrst_lo_at_dt", bus.pwm_lo, 3'b111);
    check("mrst_hi_zero_duty", bus.pwm_hi, 0);
    wait_valley(450, "mrst_next_valley", n2);
    check("mrst_default_period", n2 + 10, 400);

    // Random sweep: configs, enable drops, faults and clears.
    for (int k = 0; k < 10000; k++) begin
      bus.en = ($urandom_range(0, 299) != 0);
      bus.fault = ($urandom_range(0, 299) == 0);
      bus.fault_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) begin
        bus.duty = {CW'($urandom_range(0, 45)), CW'($urandom_range(0, 45)),
                    CW'($urandom_range(0, 45))};
        bus.half_period = CW'($urandom_range(0, 40));
        bus.deadtime = DTW'($urandom_range(0, 12));
        bus.cfg_valid = 1'b1;
      end else begin
        bus.cfg_valid = 1'b0;
      end
      step();
    end
    bus.en = 1'b1; bus.fault = 1'b0; bus.fault_clr = 1'b0; bus.cfg_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_bridge_nleg.md
# pwm_bridge_nleg

Multi-leg complementary PWM generator for the power stage: one centre-aligned up/down carrier drives `LEGS` half-bridge legs, each with its own duty and a shared programmable dead time. Duty, period and dead time pass through shadow registers and take effect only at the carrier valley, so no glitched pulses occur. A latching fault input forces all gate outputs low until software clears it. Sits between the control loop (duty producer) and the gate-driver pins.

## Interface
- `LEGS`, 3, number of half-bridge legs
- `CW`, 16, carrier/duty width in bits
- `DTW`, 8, dead-time width in bits
- `HP_RST`, 200, active half_period after reset
- `DT_RST`, 10, active deadtime after reset
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  run enable; low holds carrier at 0 and outputs low
- `duty`  in  LEGS*CW  per-leg duty, leg i at bits [i*CW +: CW]
- `half_period`  in  CW  carrier peak value
- `deadtime`  in  DTW  dead time in clk cycles
- `cfg_valid`  in  1  single-cycle strobe: capture duty/half_period/deadtime into pending
- `fault`  in  1  protection request, level, active high
- `fault_clr`  in  1  single-cycle clear of latched fault
- `pwm_hi`  out  LEGS  high-side gate, active high
- `pwm_lo`  out  LEGS  low-side gate, active high
- `fault_lat`  out  1  latched fault status
- `valley`  out  1  one-cycle pulse when shadow load occurs
- `cnt`  out  CW  current carrier value, for ADC trigger alignment

## Operation
- Carrier: counts 0→HP then HP→0; direction flips in the cycle the counter reaches HP (to down) or 0 (to up). Period = 2·HP cycles.
- Shadow: `cfg_valid` writes pending regs. At the valley (cnt==0, direction up, `en` high), pending is copied to active and `valley` pulses. A `cfg_valid` in the valley cycle lands in pending and applies at the next valley.
- Clamps on active load: HP < 2 → 2; duty > HP → HP.
- Per leg i, with D = active duty, T = active deadtime, widened to CW+1 bits with no wrap:
  - hi on when cnt + T < D
  - lo on when cnt ≥ D + T
  - The dead band between these keeps both off. If D ≤ T, hi never turns on. If D + T > HP, lo never turns on.
- Fault:
  - `fault` high sets `fault_lat` and all gates go off the next cycle.
  - `fault_clr` clears the latch only if `fault` is low in the same cycle. If both are high, the latch stays set.
  - After a clear, gates stay off until the next valley, then normal switching resumes.
- `en` low: carrier reset to 0 with direction up; gates off; pending still writable. On `en` rising, the first cycle counts as a valley (pending loads).
- Reset:
  - cnt = 0, direction up, active HP = HP_RST, DT = DT_RST, active and pending duties 0.
  - pwm_hi = pwm_lo = 0, fault_lat = 0, valley = 0.

## Timing
- Gate outputs are registered, 1 cycle after the `cnt` value that produced them.
- Fault to gates off: 1 cycle. Asynchronous paths are forbidden.
- Pending to active: loaded at the first valley after capture, at most 2·HP cycles.
- `valley` is high for exactly 1 cycle per carrier period while enabled.
- Invariant, checked every cycle: pwm_hi[i] & pwm_lo[i] == 0.

## Structure
- Shared package `pwm_pkg`: CW/DTW defaults, minimum-HP constant (2), carrier direction encoding (UP = 0, DOWN = 1).
- Sub-module `pwm_leg_cmp`: per-leg comparator plus output register, with inputs cnt, D, T, gate_en and outputs hi/lo. Instantiated LEGS times via generate.
- Carrier, shadow registers and fault latch live in the top module.

## Test plan
- HP = 10, DT = 2, duty = {5, 5, 5}: per period, hi high for cnt ∈ {0..2}, lo high for cnt ∈ {7..10}, and both low in between. Both edges of the carrier are symmetric.
- `cfg_valid` with duty0 = 8 mid-period: the outputs keep the old duty until the `valley` pulse, then switch to the new duty on the first cycle after it.
- duty0 = 1 with DT = 2: hi is never asserted. duty0 = 15 with HP = 10: duty is clamped to 10, and lo is never asserted.
- `fault` pulses at cnt = 4:
  - All gates are low the next cycle and `fault_lat` = 1.
  - `fault_clr` while `fault` is high has no effect.
  - A clear after `fault` drops resumes switching at the next valley.
- `rst` asserted mid-period: the next cycle shows cnt = 0 and all outputs 0. Active HP = 200, DT = 10.
- Random duty/HP/DT sweep over 10k cycles: hi & lo are never both high, and `valley` period = 2·HP.
